cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Debug/run controller that sequences the single-cycle CPU.
- Owns CPU reset and clock-enable.
- Streams a program into instruction memory over a valid/ready port.
- Accepts host commands: reset, load, run, pause, single-step.
- Detects CPU halt and a run-away timeout; counts executed cycles.
- Sits between the host/debug interface and the cpu top level. The CPU's PC/regfile/data-memory write enables are qualified by cpu_en.

Parameters:
ADDR_W, 8, instruction-memory address width (depth 2**ADDR_W)
INSTR_W, 16, instruction word width
CYC_W, 16, cycle counter width
TIMEOUT, 16'hFFFF, enabled-cycle limit before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command
cmd  in  3  0 RESET, 1 LOAD, 2 RUN, 3 STEP, 4 PAUSE, 5-7 illegal
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted
ld_data  in  INSTR_W  instruction word
ld_last  in  1  final word of program
cpu_halted  in  1  CPU halted flag
cpu_rst  out  1  CPU reset, registered
cpu_en  out  1  CPU advance enable
imem_we  out  1  instruction memory write strobe
imem_waddr  out  ADDR_W  write address
imem_wdata  out  INSTR_W  write data (= ld_data)
state  out  3  0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 PAUSE, 5 HALT, 6 TMO
cycle_cnt  out  CYC_W  enabled cycles since last clear
cmd_err  out  1  one-cycle pulse: illegal or disallowed command
done  out  1  one-cycle pulse on entry to HALT or TMO

Behaviour:
- Reset values: state=IDLE, cpu_rst=1, cpu_en=0, imem_we=0, imem_waddr=0, cycle_cnt=0, cmd_err=0, done=0.
- A command is accepted when cmd_valid & cmd_ready at a clock edge. The state change takes effect on that edge.
- cmd_ready=1 in IDLE, RUN, PAUSE, HALT, TMO. cmd_ready=0 in LOAD and STEP.
- Command table (anything not listed gives a cmd_err pulse and no state change; codes 5-7 always give cmd_err):
  - IDLE: RESET no-op; LOAD->LOAD; RUN->RUN; STEP->STEP. RUN/STEP from IDLE clear cycle_cnt.
  - RUN: PAUSE->PAUSE; RESET->IDLE.
  - PAUSE: RUN->RUN; STEP->STEP; PAUSE no-op; RESET->IDLE.
  - HALT/TMO: RESET->IDLE; LOAD->LOAD.
- LOAD:
  - Entry clears imem_waddr and cycle_cnt.
  - ld_ready=1 only in LOAD.
  - imem_we = ld_valid & ld_ready (combinational); imem_wdata = ld_data; imem_waddr is registered.
  - Each beat increments imem_waddr. No beat occurs when ld_valid=0.
  - A beat with ld_last=1, or a beat at address 2**ADDR_W-1, returns to IDLE and resets imem_waddr to 0. No wrap-around overwrite.
- cpu_rst:
  - Register whose next value is (next_state is IDLE or LOAD).
  - Deasserts on the same edge that enters RUN/STEP from IDLE.
  - Stays deasserted through RUN, STEP, PAUSE, HALT, TMO so the architectural state remains inspectable.
- cpu_en = (state==RUN or state==STEP) & !cpu_halted. Combinational from registered state.
- cycle_cnt increments on every edge where cpu_en=1 and saturates at all-ones.
- RUN exit priority, per cycle: cpu_halted -> HALT; else cycle_cnt==TIMEOUT-1 with cpu_en -> TMO; else accepted PAUSE/RESET command.
- STEP: exactly one cycle with cpu_en=1. Then PAUSE, or HALT if cpu_halted is observed.
- PAUSE with cpu_halted=1 (set by the last step) -> HALT next cycle.
- done pulses on the cycle after entering HALT or TMO.
- Async rst mid-LOAD or mid-RUN: immediate return to reset values. Partially written imem contents are not cleared.

Decomposition:
- Package cpu_ctrl_pkg: state encoding, command codes, default TIMEOUT.
- One natural sub-module: sat_counter (CYC_W, clear, enable, saturate), used for cycle_cnt.
- The FSM and load addressing stay in cpu_run_ctrl.

Test Plan:
1. Reset, LOAD, stream 4 words with ld_last on the 4th -> imem_we on 4 cycles at addresses 0..3 with matching data; state returns to IDLE; imem_waddr=0; cpu_rst stays 1 throughout.
2. Stream 256 words with no ld_last -> final write at address 255; exit to IDLE; no write to address 0 afterward.
3. RUN with a model CPU that raises cpu_halted after 10 enabled cycles -> cpu_rst falls on the accept edge; cycle_cnt=10; state=HALT; one done pulse; cpu_en=0 after halt.
4. RUN, then PAUSE after 3 cycles, then STEP twice, then RUN -> cycle_cnt 3, 4, 5 across the steps; each STEP gives exactly one cpu_en cycle; cpu_rst never reasserts.
5. TIMEOUT=20 with a CPU that never halts -> TMO when cycle_cnt=20; done pulses; RUN in TMO gives cmd_err; RESET -> IDLE with cpu_rst=1.
6. Illegal cmd=6 in IDLE, RUN in HALT, and a PAUSE coinciding with cpu_halted -> two cmd_err pulses; the coincident case ends in HALT, not PAUSE. Asserting rst mid-RUN restores all reset values asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and command legality table for the CPU run/debug controller.
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned CYC_W_DEF   = 16;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_HALT  = 3'd5,
    ST_TMO   = 3'd6
  } state_e;

  localparam logic [2:0] CMD_RESET = 3'd0;
  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [2:0] CMD_RUN   = 3'd2;
  localparam logic [2:0] CMD_STEP  = 3'd3;
  localparam logic [2:0] CMD_PAUSE = 3'd4;

  typedef struct packed {
    logic   ok;
    state_e nxt;
  } cmd_res_t;

  // Command legality and target state; ok=0 means the command is rejected.
  function automatic cmd_res_t cmd_lookup(input state_e st, input logic [2:0] c);
    cmd_res_t r;
    r.ok  = 1'b0;
    r.nxt = st;
    case (st)
      ST_IDLE: begin
        case (c)
          CMD_RESET: r.ok = 1'b1;
          CMD_LOAD:  begin r.ok = 1'b1; r.nxt = ST_LOAD; end
          CMD_RUN:   begin r.ok = 1'b1; r.nxt = ST_RUN;  end
          CMD_STEP:  begin r.ok = 1'b1; r.nxt = ST_STEP; end
          default:   r.ok = 1'b0;
        endcase
      end
      ST_RUN: begin
        case (c)
          CMD_PAUSE: begin r.ok = 1'b1; r.nxt = ST_PAUSE; end
          CMD_RESET: begin r.ok = 1'b1; r.nxt = ST_IDLE;  end
          default:   r.ok = 1'b0;
        endcase
      end
      ST_PAUSE: begin
        case (c)
          CMD_RUN:   begin r.ok = 1'b1; r.nxt = ST_RUN;  end
          CMD_STEP:  begin r.ok = 1'b1; r.nxt = ST_STEP; end
          CMD_PAUSE: r.ok = 1'b1;
          CMD_RESET: begin r.ok = 1'b1; r.nxt = ST_IDLE; end
          default:   r.ok = 1'b0;
        endcase
      end
      ST_HALT, ST_TMO: begin
        case (c)
          CMD_RESET: begin r.ok = 1'b1; r.nxt = ST_IDLE; end
          CMD_LOAD:  begin r.ok = 1'b1; r.nxt = ST_LOAD; end
          default:   r.ok = 1'b0;
        endcase
      end
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host/debug command, program-load and CPU control bundle for cpu_run_ctrl.
interface cpu_run_ctrl_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CYC_W   = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd;
  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               cpu_halted;
  logic               cpu_rst;
  logic               cpu_en;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [2:0]         state;
  logic [CYC_W-1:0]   cycle_cnt;
  logic               cmd_err;
  logic               done;

  modport master (
    output cmd_valid, cmd, ld_valid, ld_data, ld_last, cpu_halted,
    input  cmd_ready, ld_ready, cpu_rst, cpu_en, imem_we, imem_waddr,
           imem_wdata, state, cycle_cnt, cmd_err, done
  );

  modport slave (
    input  cmd_valid, cmd, ld_valid, ld_data, ld_last, cpu_halted,
    output cmd_ready, ld_ready, cpu_rst, cpu_en, imem_we, imem_waddr,
           imem_wdata, state, cycle_cnt, cmd_err, done
  );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (en && cnt != {W{1'b1}})  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug controller: owns CPU reset/enable, program load, halt and timeout detection.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned      ADDR_W  = ADDR_W_DEF,
  parameter int unsigned      INSTR_W = INSTR_W_DEF,
  parameter int unsigned      CYC_W   = CYC_W_DEF,
  parameter logic [CYC_W-1:0] TIMEOUT = CYC_W'(TIMEOUT_DEF)
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);
  state_e            st, nxt;
  cmd_res_t          res;
  logic              acc, beat, load_end, tmo_hit, err_c, clr_c;
  logic              cpu_rst_q, err_q, done_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [CYC_W-1:0]  cnt;

  assign bus.cmd_ready  = st inside {ST_IDLE, ST_RUN, ST_PAUSE, ST_HALT, ST_TMO};
  assign bus.ld_ready   = (st == ST_LOAD);
  assign bus.cpu_en     = (st == ST_RUN || st == ST_STEP) && !bus.cpu_halted;
  assign bus.imem_we    = bus.ld_valid & bus.ld_ready;
  assign bus.imem_wdata = bus.ld_data;
  assign bus.imem_waddr = waddr_q;
  assign bus.state      = st;
  assign bus.cycle_cnt  = cnt;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.cmd_err    = err_q;
  assign bus.done       = done_q;

  assign res      = cmd_lookup(st, bus.cmd);
  assign acc      = bus.cmd_valid & bus.cmd_ready;
  assign beat     = bus.imem_we;
  assign load_end = beat & (bus.ld_last | (waddr_q == {ADDR_W{1'b1}}));
  assign tmo_hit  = bus.cpu_en && (cnt == TIMEOUT - CYC_W'(1));

  // Halt and timeout pre-empt any command arriving in the same cycle.
  always_comb begin
    nxt   = st;
    err_c = acc & ~res.ok;
    clr_c = acc & res.ok &
            ((res.nxt == ST_LOAD) | ((st == ST_IDLE) & (res.nxt inside {ST_RUN, ST_STEP})));
    case (st)
      ST_LOAD:  if (load_end) nxt = ST_IDLE;
      ST_STEP:  nxt = bus.cpu_halted ? ST_HALT : ST_PAUSE;
      ST_RUN: begin
        if (bus.cpu_halted)     nxt = ST_HALT;
        else if (tmo_hit)       nxt = ST_TMO;
        else if (acc && res.ok) nxt = res.nxt;
      end
      ST_PAUSE: begin
        if (bus.cpu_halted)     nxt = ST_HALT;
        else if (acc && res.ok) nxt = res.nxt;
      end
      default:  if (acc && res.ok) nxt = res.nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      cpu_rst_q <= 1'b1;
      waddr_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st        <= nxt;
      cpu_rst_q <= (nxt == ST_IDLE) || (nxt == ST_LOAD);
      err_q     <= err_c;
      done_q    <= (nxt == ST_HALT || nxt == ST_TMO) && (st != nxt);
      if (st != ST_LOAD && nxt == ST_LOAD) waddr_q <= '0;
      else if (beat)                       waddr_q <= load_end ? '0 : waddr_q + ADDR_W'(1);
    end
  end

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (clr_c),
    .en  (bus.cpu_en),
    .cnt (cnt)
  );
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed bench for cpu_run_ctrl against a table-driven behavioural model.
module tb_cpu_run_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 16;
  localparam int TMO_LIM = 20;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_STEP = 3, S_PAUSE = 4, S_HALT = 5, S_TMO = 6;
  localparam logic [2:0] C_RESET = 3'd0, C_LOAD = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3, C_PAUSE = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_run_ctrl_if #(.ADDR_W(AW), .INSTR_W(IW), .CYC_W(CW)) ifc ();

  cpu_run_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .CYC_W(CW), .TIMEOUT(16'd20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: legal-command table plus spec-level rules.
  int tbl [7][8];
  int m_st = S_IDLE, m_waddr = 0, m_cnt = 0, en_seen = 0;
  bit m_rst = 1'b1, m_err = 1'b0, m_done = 1'b0;

  initial begin
    for (int s = 0; s < 7; s++) for (int c = 0; c < 8; c++) tbl[s][c] = -1;
    tbl[S_IDLE][0] = S_IDLE;  tbl[S_IDLE][1] = S_LOAD;  tbl[S_IDLE][2] = S_RUN;  tbl[S_IDLE][3] = S_STEP;
    tbl[S_RUN][0]  = S_IDLE;  tbl[S_RUN][4]  = S_PAUSE;
    tbl[S_PAUSE][0] = S_IDLE; tbl[S_PAUSE][2] = S_RUN;  tbl[S_PAUSE][3] = S_STEP; tbl[S_PAUSE][4] = S_PAUSE;
    tbl[S_HALT][0] = S_IDLE;  tbl[S_HALT][1] = S_LOAD;
    tbl[S_TMO][0]  = S_IDLE;  tbl[S_TMO][1]  = S_LOAD;
  end

  always @(posedge clk or posedge rst) begin : model
    int ns, tgt;
    bit en, acc, hlt;
    if (rst) begin
      m_st = S_IDLE; m_rst = 1'b1; m_waddr = 0; m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
    end else begin
      hlt = (ifc.cpu_halted === 1'b1);
      en  = (m_st == S_RUN || m_st == S_STEP) && !hlt;
      acc = ifc.cmd_valid && (m_st != S_LOAD && m_st != S_STEP);
      tgt = tbl[m_st][ifc.cmd];
      ns  = m_st;
      m_err = acc && (tgt < 0);
      if (m_st == S_LOAD) begin
        if (ifc.ld_valid) begin
          if (ifc.ld_last || m_waddr == (1 << AW) - 1) begin ns = S_IDLE; m_waddr = 0; end
          else m_waddr++;
        end
      end else if (m_st == S_STEP) ns = hlt ? S_HALT : S_PAUSE;
      else if ((m_st == S_RUN || m_st == S_PAUSE) && hlt) ns = S_HALT;
      else if (m_st == S_RUN && en && m_cnt == TMO_LIM - 1) ns = S_TMO;
      else if (acc && tgt >= 0) ns = tgt;
      if (ns != m_st && (ns == S_LOAD || (m_st == S_IDLE && (ns == S_RUN || ns == S_STEP)))) begin
        m_cnt = 0;
        if (ns == S_LOAD) m_waddr = 0;
      end else if (en && m_cnt < 65535) m_cnt++;
      if (en) en_seen++;
      m_done = (ns == S_HALT || ns == S_TMO) && ns != m_st;
      m_rst  = (ns == S_IDLE || ns == S_LOAD);
      m_st   = ns;
    end
  end

  int unsigned wr_q[$];
  int unsigned wd_q[$];
  int err_seen = 0, done_seen = 0;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit en, rdy, we;
    en  = (m_st == S_RUN || m_st == S_STEP) && !ifc.cpu_halted;
    rdy = (m_st != S_LOAD && m_st != S_STEP);
    we  = ifc.ld_valid && (m_st == S_LOAD);
    chk("state", 32'(ifc.state), 32'(m_st));
    chk("cpu_rst", 32'(ifc.cpu_rst), 32'(m_rst));
    chk("cpu_en", 32'(ifc.cpu_en), 32'(en));
    chk("cmd_ready", 32'(ifc.cmd_ready), 32'(rdy));
    chk("ld_ready", 32'(ifc.ld_ready), 32'(m_st == S_LOAD));
    chk("imem_we", 32'(ifc.imem_we), 32'(we));
    chk("imem_waddr", 32'(ifc.imem_waddr), 32'(m_waddr));
    if (we) chk("imem_wdata", 32'(ifc.imem_wdata), 32'(ifc.ld_data));
    chk("cycle_cnt", 32'(ifc.cycle_cnt), 32'(m_cnt));
    chk("cmd_err", 32'(ifc.cmd_err), 32'(m_err));
    chk("done", 32'(ifc.done), 32'(m_done));
    if (ifc.imem_we === 1'b1) begin
      wr_q.push_back(32'(ifc.imem_waddr));
      wd_q.push_back(32'(ifc.imem_wdata));
    end
    if (ifc.cmd_err === 1'b1) err_seen++;
    if (ifc.done === 1'b1) done_seen++;
  end

  int halt_after = -1;
  bit force_halt = 1'b0;
  int unsigned sent_q[$];

  task automatic tick();
    @(posedge clk);
    #2;
    ifc.cpu_halted = force_halt || (halt_after >= 0 && en_seen >= halt_after);
  endtask

  task automatic send_cmd(input logic [2:0] c);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd = c;
    while (!ok && n < 20) begin
      #1;
      ok = ifc.cmd_ready;
      tick();
      n++;
    end
    if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic load_stream(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin ifc.ld_valid = 1'b0; tick(); end
      ifc.ld_valid = 1'b1;
      ifc.ld_data  = IW'($urandom);
      ifc.ld_last  = use_last && (i == n - 1);
      sent_q.push_back(32'(ifc.ld_data));
      tick();
    end
    ifc.ld_valid = 1'b0;
    ifc.ld_last  = 1'b0;
  endtask

  task automatic wait_state(input int s, input int bound);
    for (int n = 0; n < bound && int'(ifc.state) != s; n++) tick();
    chk("wait_state", 32'(ifc.state), 32'(s));
  endtask

  initial begin
    int i0, e0, d0, s0;
    ifc.cmd_valid = 1'b0; ifc.cmd = 3'd0; ifc.ld_valid = 1'b0;
    ifc.ld_data = '0; ifc.ld_last = 1'b0; ifc.cpu_halted = 1'b0;
    #12;
    chk("rst_state", 32'(ifc.state), 32'd0);
    chk("rst_cpu_rst", 32'(ifc.cpu_rst), 32'd1);
    chk("rst_cycle_cnt", 32'(ifc.cycle_cnt), 32'd0);
    #5 rst = 1'b0;

    // Short program terminated by ld_last.
    send_cmd(C_LOAD);
    i0 = wr_q.size();
    sent_q.delete();
    load_stream(4, 1'b1);
    tick();
    chk("t1_writes", 32'(wr_q.size() - i0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", wr_q[i0 + k], 32'(k));
      chk("t1_data", wd_q[i0 + k], sent_q[k]);
    end
    chk("t1_state", 32'(ifc.state), 32'(S_IDLE));
    chk("t1_waddr", 32'(ifc.imem_waddr), 32'd0);
    chk("t1_cpu_rst", 32'(ifc.cpu_rst), 32'd1);

    // Full-depth program without ld_last; no wrap-around.
    send_cmd(C_LOAD);
    i0 = wr_q.size();
    load_stream(256, 1'b0);
    ifc.ld_valid = 1'b1; tick(); tick(); ifc.ld_valid = 1'b0;
    chk("t2_writes", 32'(wr_q.size() - i0), 32'd256);
    chk("t2_last_addr", wr_q[wr_q.size() - 1], 32'd255);
    chk("t2_state", 32'(ifc.state), 32'(S_IDLE));

    // Run until the CPU halts after 10 enabled cycles.
    d0 = done_seen;
    halt_after = en_seen + 10;
    chk("t3_rst_before", 32'(ifc.cpu_rst), 32'd1);
    send_cmd(C_RUN);
    chk("t3_rst_after", 32'(ifc.cpu_rst), 32'd0);
    wait_state(S_HALT, 50);
    tick(); tick();
    chk("t3_cycle_cnt", 32'(ifc.cycle_cnt), 32'd10);
    chk("t3_done", 32'(done_seen - d0), 32'd1);
    chk("t3_cpu_en", 32'(ifc.cpu_en), 32'd0);

    // Pause after 3 cycles, two single steps, resume.
    halt_after = -1;
    send_cmd(C_RESET);
    send_cmd(C_RUN);
    tick(); tick();
    send_cmd(C_PAUSE);
    chk("t4_paused", 32'(ifc.state), 32'(S_PAUSE));
    chk("t4_cnt3", 32'(ifc.cycle_cnt), 32'd3);
    s0 = en_seen;
    send_cmd(C_STEP); tick();
    chk("t4_cnt4", 32'(ifc.cycle_cnt), 32'd4);
    chk("t4_step_en1", 32'(en_seen - s0), 32'd1);
    send_cmd(C_STEP); tick();
    chk("t4_cnt5", 32'(ifc.cycle_cnt), 32'd5);
    chk("t4_step_en2", 32'(en_seen - s0), 32'd2);
    send_cmd(C_RUN); tick(); tick();
    chk("t4_cpu_rst", 32'(ifc.cpu_rst), 32'd0);

    // Timeout with a CPU that never halts.
    send_cmd(C_RESET);
    d0 = done_seen;
    e0 = err_seen;
    send_cmd(C_RUN);
    wait_state(S_TMO, 40);
    chk("t5_cycle_cnt", 32'(ifc.cycle_cnt), 32'd20);
    tick();
    chk("t5_done", 32'(done_seen - d0), 32'd1);
    send_cmd(C_RUN); tick();
    chk("t5_err", 32'(err_seen - e0), 32'd1);
    send_cmd(C_RESET);
    chk("t5_state", 32'(ifc.state), 32'(S_IDLE));
    chk("t5_cpu_rst", 32'(ifc.cpu_rst), 32'd1);

    // Illegal code, disallowed RUN in HALT, PAUSE coinciding with halt.
    e0 = err_seen;
    send_cmd(3'd6);
    halt_after = en_seen + 2;
    send_cmd(C_RUN);
    wait_state(S_HALT, 20);
    send_cmd(C_RUN);
    halt_after = -1;
    send_cmd(C_RESET);
    send_cmd(C_RUN); tick(); tick();
    force_halt = 1'b1;
    ifc.cpu_halted = 1'b1;
    send_cmd(C_PAUSE); tick();
    chk("t6_state", 32'(ifc.state), 32'(S_HALT));
    chk("t6_errs", 32'(err_seen - e0), 32'd2);
    force_halt = 1'b0;
    send_cmd(C_RESET);

    // Asynchronous reset in the middle of a run.
    send_cmd(C_RUN); tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_state", 32'(ifc.state), 32'd0);
    chk("ar_cpu_rst", 32'(ifc.cpu_rst), 32'd1);
    chk("ar_cpu_en", 32'(ifc.cpu_en), 32'd0);
    chk("ar_cycle_cnt", 32'(ifc.cycle_cnt), 32'd0);
    chk("ar_waddr", 32'(ifc.imem_waddr), 32'd0);
    chk("ar_err", 32'(ifc.cmd_err), 32'd0);
    chk("ar_done", 32'(ifc.done), 32'd0);
    tick();
    rst = 1'b0;

    // Random traffic, including occasional asynchronous resets.
    for (int it = 0; it < 3000; it++) begin
      ifc.cmd_valid = ($urandom_range(2) == 0);
      ifc.cmd       = 3'($urandom_range(7));
      ifc.ld_valid  = $urandom_range(1) == 1;
      ifc.ld_data   = IW'($urandom);
      ifc.ld_last   = ($urandom_range(15) == 0);
      force_halt    = ($urandom_range(11) == 0);
      if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    ifc.cmd_valid = 1'b0;
    ifc.ld_valid  = 1'b0;
    force_halt    = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
